// File: rtl/pe_seq_ctrl.sv
// Sequencer for a NUM_PE-deep processing-element array.
// It accepts one command, configures the PE mode, and streams cmd_len input
// beats into the array. It then drains the array's valid pipe and pulses done.
module pe_seq_ctrl #(
  parameter int NUM_PE = 4,
  parameter int CNT_BW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_BW-1:0] cmd_len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        gemm_uno,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BW-1:0]   remaining_q, remaining_d;
  logic [1:0]          uno_q, uno_d;
  logic [NUM_PE-1:0]   pipe_q, pipe_d;
  logic                beat;
  logic                pipe_clr;

  // Next-state, counter and handshake decode; abort overrides everything last.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    uno_d       = uno_q;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    done        = 1'b0;
    pipe_clr    = 1'b0;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cmd_ready = ~abort;
        if (cmd_valid && !abort) begin
          uno_d       = cmd_op;
          remaining_d = cmd_len;
          state_d     = S_CFG;
        end
      end
      S_CFG: begin
        state_d = (remaining_q != '0) ? S_FEED : S_DONE;
      end
      S_FEED: begin
        in_ready = 1'b1;
        if (in_valid) begin
          remaining_d = remaining_q - CNT_BW'(1);
          if (remaining_q == CNT_BW'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Wait until every beat in flight has left the array.
        if (pipe_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A cancelled command leaves nothing behind: no beats, no results, no done.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      remaining_d = '0;
      in_ready    = 1'b0;
      done        = 1'b0;
      pipe_clr    = 1'b1;
    end

    beat = in_valid & in_ready;
  end

  // Valid pipe mirrors the PE latency: a beat fed now emerges NUM_PE cycles later.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_d[gi] = ~pipe_clr & beat;
      end else begin : g_tail
        assign pipe_d[gi] = ~pipe_clr & pipe_q[gi-1];
      end
    end
  endgenerate

  // State, counter, mode and valid-pipe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      uno_q       <= 2'b00;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      uno_q       <= uno_d;
      pipe_q      <= pipe_d;
    end
  end

  assign gemm_uno  = uno_q;
  assign out_valid = pipe_q[NUM_PE-1];

endmodule
